// File: rtl/io_pkg.sv
// Shared definitions for the I/O unit: seven-segment codes, FSM state
// encodings and the BCD-nibble to segment mapping.
package io_pkg;

  // Active-low segments, bit 6 = g ... bit 0 = a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic {
    OUT_IDLE,
    OUT_CONV
  } out_state_t;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_WAIT_PRESS,
    IN_WAIT_RELEASE,
    IN_DONE
  } in_state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/io_unit_bin2bcd.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// done is a single-cycle strobe on the final step; bcd carries the finished
// result during that same cycle so the caller can register it on that edge.
//
// state    | meaning
// OUT_IDLE | waiting for start
// OUT_CONV | shifting, cnt = steps remaining after this one
module bin2bcd_seq
  import io_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BCD_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  out_state_t state, state_next;
  logic [DATA_W-1:0] shreg;
  logic [4*BCD_DIGITS-1:0] acc, acc_adj, acc_next;
  logic [CNT_W-1:0] cnt;

  // add-3 correction on every digit, then shift in the next binary bit
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = (acc_adj << 1) | {{(4*BCD_DIGITS-1){1'b0}}, shreg[DATA_W-1]};
  end

  // next state; a start in either state restarts from the new value
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      OUT_IDLE: if (start) state_next = OUT_CONV;
      OUT_CONV: begin
        if (start) state_next = OUT_CONV;
        else if (cnt == '0) begin
          done       = 1'b1;
          state_next = OUT_IDLE;
        end
      end
      default: state_next = OUT_IDLE;
    endcase
  end

  // state register and datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= OUT_IDLE;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        shreg <= bin;
        acc   <= '0;
        cnt   <= LAST;
      end else if (state == OUT_CONV) begin
        shreg <= shreg << 1;
        acc   <= acc_next;
        cnt   <= cnt - CNT_W'(1);
      end
    end
  end

  assign busy = (state == OUT_CONV);
  assign bcd  = acc_next;

endmodule

// File: rtl/io_unit.sv
// I/O unit: sequential BCD display driver plus debounced enter-button
// handshake for the core's input instruction.
// Build option: define IO_SIGNED_EN to display out_data as two's complement
// with a minus sign on the top digit.
//
// state           | meaning
// IN_IDLE         | no input request pending
// IN_WAIT_PRESS   | waiting for a fresh debounced press
// IN_WAIT_RELEASE | pressed, waiting for release to capture switches
// IN_DONE         | capture done, in_valid pulses
module io_unit
  import io_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int SW_W         = 16,
  parameter int DIGITS       = 8,
  parameter int DEBOUNCE_CYC = 16,
  parameter int BLANK_LZ     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  out_we,
  input  logic [DATA_W-1:0]     out_data,
  output logic                  out_busy,
  output logic                  out_ovf,
  output logic [7*DIGITS-1:0]   seg,
  input  logic                  in_req,
  input  logic                  ent,
  input  logic [SW_W-1:0]       switch,
  output logic                  in_valid,
  output logic [DATA_W-1:0]     in_data
);

  localparam int BCD_DIGITS = 10;
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [DATA_W-1:0] conv_bin;
  logic neg_q;
  logic conv_done;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] seg_calc;
  logic ovf_calc;

`ifdef IO_SIGNED_EN
  logic neg;
  assign neg      = out_data[DATA_W-1];
  assign conv_bin = neg ? -out_data : out_data;

  // sign is latched with the value so a restart picks up the new sign
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) neg_q <= 1'b0;
    else if (out_we) neg_q <= neg;
  end
`else
  assign neg_q    = 1'b0;
  assign conv_bin = out_data;
`endif

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .BCD_DIGITS(BCD_DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .reset(reset),
    .start(out_we),
    .bin  (conv_bin),
    .busy (out_busy),
    .done (conv_done),
    .bcd  (bcd)
  );

  // map the finished BCD value to segments: sign, leading-zero blanking, overflow
  always_comb begin
    int  mag_digits;
    logic lead;
    mag_digits = neg_q ? DIGITS - 1 : DIGITS;
    ovf_calc   = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (i >= mag_digits && bcd[4*i +: 4] != 4'd0) ovf_calc = 1'b1;
    end
    lead     = (BLANK_LZ != 0);
    seg_calc = {DIGITS{SEG_BLANK}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i >= mag_digits) begin
        seg_calc[7*i +: 7] = SEG_MINUS;
      end else if (lead && i != 0 && bcd[4*i +: 4] == 4'd0) begin
        seg_calc[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_calc[7*i +: 7] = bcd_to_seg(bcd[4*i +: 4]);
        lead = 1'b0;
      end
    end
  end

  // display registers change only when a conversion completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg     <= {DIGITS{SEG_BLANK}};
      out_ovf <= 1'b0;
    end else if (conv_done) begin
      seg     <= seg_calc;
      out_ovf <= ovf_calc;
    end
  end

  logic sync1, sync2, deb, flip;
  logic [DB_W-1:0] deb_cnt;

  // flip happens on the edge where the debounced level toggles
  assign flip = (sync2 != deb) && (deb_cnt == DB_LAST);

  // synchroniser and debounce: level follows after DEBOUNCE_CYC disagreeing cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      deb     <= 1'b1;
      deb_cnt <= '0;
    end else begin
      sync1 <= ent;
      sync2 <= sync1;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (flip) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DB_W'(1);
      end
    end
  end

  in_state_t in_state, in_next;
  logic capture;

  // input handshake next state; a press must be seen falling inside WAIT_PRESS
  always_comb begin
    in_next = in_state;
    capture = 1'b0;
    case (in_state)
      IN_IDLE: if (in_req) in_next = IN_WAIT_PRESS;
      IN_WAIT_PRESS: begin
        if (!in_req) in_next = IN_IDLE;
        else if (flip && deb) in_next = IN_WAIT_RELEASE;
      end
      IN_WAIT_RELEASE: begin
        if (!in_req) in_next = IN_IDLE;
        else if (flip && !deb) begin
          in_next = IN_DONE;
          capture = 1'b1;
        end
      end
      IN_DONE: in_next = IN_IDLE;
      default: in_next = IN_IDLE;
    endcase
  end

  // input state, capture register and valid pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_state <= IN_IDLE;
      in_data  <= '0;
      in_valid <= 1'b0;
    end else begin
      in_state <= in_next;
      in_valid <= (in_next == IN_DONE);
      if (capture) in_data <= DATA_W'(switch);
    end
  end

endmodule

// File: tb/tb_io_unit.sv
// Bench for io_unit: two instances (BLANK_LZ 0 and 1) share all inputs.
// Expected display/input results are queued at stimulus time and checked by
// monitors when a conversion ends or in_valid pulses.
module tb_io_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic out_we = 1'b0;
  logic [31:0] out_data = '0;
  logic in_req = 1'b0;
  logic ent = 1'b1;
  logic [15:0] switch = '0;

  logic busy0, ovf0, valid0, busy1, ovf1, valid1;
  logic [55:0] seg0, seg1;
  logic [31:0] data0, data1;

  always #5 clk = ~clk;

  io_unit #(.DATA_W(32), .SW_W(16), .DIGITS(8), .DEBOUNCE_CYC(4), .BLANK_LZ(0)) dut (
    .clk(clk), .reset(reset), .out_we(out_we), .out_data(out_data),
    .out_busy(busy0), .out_ovf(ovf0), .seg(seg0),
    .in_req(in_req), .ent(ent), .switch(switch),
    .in_valid(valid0), .in_data(data0)
  );

  io_unit #(.DATA_W(32), .SW_W(16), .DIGITS(8), .DEBOUNCE_CYC(4), .BLANK_LZ(1)) dut_blank (
    .clk(clk), .reset(reset), .out_we(out_we), .out_data(out_data),
    .out_busy(busy1), .out_ovf(ovf1), .seg(seg1),
    .in_req(in_req), .ent(ent), .switch(switch),
    .in_valid(valid1), .in_data(data1)
  );

  typedef struct {
    logic [55:0] seg;
    logic [55:0] seg_b;
    logic        ovf;
    int          busy_len;
  } out_exp_t;

  out_exp_t out_q[$];
  logic [31:0] in_q[$];
  int total = 0;
  int passed = 0;
  int n_valid = 0;

  // hand-written digit string -> segments; nibble E = minus, F = blank
  function automatic logic [55:0] enc(input logic [31:0] d);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) begin
      case (d[4*i +: 4])
        4'h0: r[7*i +: 7] = 7'b1000000;
        4'h1: r[7*i +: 7] = 7'b1111001;
        4'h2: r[7*i +: 7] = 7'b0100100;
        4'h3: r[7*i +: 7] = 7'b0110000;
        4'h4: r[7*i +: 7] = 7'b0011001;
        4'h5: r[7*i +: 7] = 7'b0010010;
        4'h6: r[7*i +: 7] = 7'b0000010;
        4'h7: r[7*i +: 7] = 7'b1111000;
        4'h8: r[7*i +: 7] = 7'b0000000;
        4'h9: r[7*i +: 7] = 7'b0010000;
        4'hE: r[7*i +: 7] = 7'b0111111;
        default: r[7*i +: 7] = 7'b1111111;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_out(input logic [31:0] d, input logic [31:0] db, input logic ovf, input int len);
    out_exp_t e;
    e.seg = enc(d);
    e.seg_b = enc(db);
    e.ovf = ovf;
    e.busy_len = len;
    out_q.push_back(e);
  endtask

  task automatic strobe(input logic [31:0] v);
    @(negedge clk);
    out_data = v;
    out_we = 1'b1;
    @(negedge clk);
    out_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy0) begin
      total++;
      $display("FAIL %s timeout: out_busy still 1 after 200 cycles, expected 0", name);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input int target, input string name);
    int k;
    k = 0;
    while (n_valid < target && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (n_valid < target) begin
      total++;
      $display("FAIL %s timeout: %0d in_valid pulses, expected %0d", name, n_valid, target);
    end
  endtask

  task automatic ent_level(input logic v, input int n);
    ent = v;
    repeat (n) @(negedge clk);
  endtask

  // display monitor: compares on the cycle out_busy falls
  initial begin : out_mon
    int cnt;
    out_exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) cnt = 0;
      else if (busy0) cnt++;
      else if (cnt > 0) begin
        if (out_q.size() == 0) begin
          total++;
          $display("FAIL out_unexpected: display update seen, none expected");
        end else begin
          e = out_q.pop_front();
          check("seg", seg0, e.seg);
          check("seg_blank", seg1, e.seg_b);
          check("ovf", ovf0, e.ovf);
          check("busy_len", cnt, e.busy_len);
        end
        cnt = 0;
      end
    end
  end

  // input monitor: compares on every in_valid pulse
  initial begin : in_mon
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (reset && valid0) begin
        n_valid++;
        if (in_q.size() == 0) begin
          total++;
          $display("FAIL in_unexpected: in_valid pulse with in_data %h, none expected", data0);
        end else begin
          x = in_q.pop_front();
          check("in_data", data0, x);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    check("rst_seg", seg0, {8{7'b1111111}});
    check("rst_busy", busy0, 0);
    check("rst_valid", valid0, 0);
    check("rst_in_data", data0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    push_out(32'h00001234, 32'hFFFF1234, 1'b0, 32);
    strobe(32'd1234);
    wait_idle("disp_1234");

    push_out(32'h00000007, 32'hFFFFFFF7, 1'b0, 32);
    strobe(32'd7);
    wait_idle("disp_7");

    push_out(32'h00000009, 32'hFFFFFFF9, 1'b0, 37);
    strobe(32'd5);
    repeat (3) @(negedge clk);
    strobe(32'd9);
    wait_idle("restart");

`ifdef IO_SIGNED_EN
    push_out(32'hE0000005, 32'hEFFFFFF5, 1'b0, 32);
    strobe(-32'sd5);
    wait_idle("neg5");
    push_out(32'hE7483648, 32'hE7483648, 1'b1, 32);
    strobe(32'h80000000);
    wait_idle("most_neg");
    push_out(32'hE0000001, 32'hEFFFFFF1, 1'b0, 32);
`else
    push_out(32'h94967295, 32'h94967295, 1'b1, 32);
`endif
    strobe(32'hFFFFFFFF);
    wait_idle("all_ones");

    in_req = 1'b1;
    switch = 16'h00A5;
    in_q.push_back(32'h000000A5);
    repeat (3) @(negedge clk);
    ent_level(1'b0, 1);
    ent_level(1'b1, 1);
    ent_level(1'b0, 1);
    ent_level(1'b0, 10);
    ent_level(1'b1, 12);
    wait_valid(1, "hs_a5");
    in_req = 1'b0;
    repeat (5) @(negedge clk);
    check("pulse_count_a5", n_valid, 1);

    in_req = 1'b1;
    repeat (3) @(negedge clk);
    ent_level(1'b0, 10);
    in_req = 1'b0;
    ent_level(1'b1, 15);
    check("pulse_count_abort", n_valid, 1);

    ent_level(1'b0, 10);
    in_req = 1'b1;
    switch = 16'h1234;
    repeat (10) @(negedge clk);
    ent_level(1'b1, 12);
    check("pulse_count_held", n_valid, 1);
    in_q.push_back(32'h00001234);
    ent_level(1'b0, 10);
    ent_level(1'b1, 12);
    wait_valid(2, "hs_repress");
    in_req = 1'b0;
    repeat (5) @(negedge clk);
    check("pulse_count_repress", n_valid, 2);

    strobe(32'd42);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_seg", seg0, {8{7'b1111111}});
    check("midrst_seg_blank", seg1, {8{7'b1111111}});
    check("midrst_busy", busy0, 0);
    check("midrst_ovf", ovf0, 0);
    check("midrst_valid", valid0, 0);
    check("midrst_in_data", data0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    push_out(32'h00000000, 32'hFFFFFFF0, 1'b0, 32);
    strobe(32'd0);
    wait_idle("disp_0");

    check("out_q_empty", out_q.size(), 0);
    check("in_q_empty", in_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
